// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package sram_arb_pkg;

  // Which port a registered response belongs to.
  typedef enum logic [1:0] {
    OWNER_NONE  = 2'd0,
    OWNER_INSTR = 2'd1,
    OWNER_DATA  = 2'd2
  } owner_e;

  // One tracker entry per grant: who gets the rvalid and whether it is an error.
  typedef struct packed {
    owner_e owner;
    logic   err;
  } resp_t;

  // True when addr falls inside the power-of-two window [start, start+size).
  function automatic logic in_range(input logic [31:0] addr,
                                    input logic [31:0] start,
                                    input logic [31:0] size);
    return (addr & ~(size - 32'd1)) == start;
  endfunction

endpackage

// File: rtl/sram_arb_resp.sv
// Response tracker: registers {owner, err, write} per grant and demuxes the SRAM read data.
// Latency: rvalid exactly one cycle after the grant; back-to-back grants give back-to-back rvalids.
// Backpressure: none; the core always accepts responses.
// Ports: clk_sys/rst_sys_n; resp_i/wr_i = this cycle's grant; mem_rdata_i = SRAM data;
//        instr_*/data_* rvalid, rdata, err outputs to the core.
module sram_arb_resp
  import sram_arb_pkg::*;
(
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  resp_t       resp_i,
  input  logic        wr_i,
  input  logic [31:0] mem_rdata_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o
);

  resp_t       resp_d, resp_q;
  logic        wr_d, wr_q;
  logic [31:0] rdata;

  always_comb begin
    resp_d = resp_i;
    wr_d   = wr_i;
  end

  // Reset discards any pending response, so no rvalid follows a reset.
  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      resp_q <= '{owner: OWNER_NONE, err: 1'b0};
      wr_q   <= 1'b0;
    end else begin
      resp_q <= resp_d;
      wr_q   <= wr_d;
    end
  end

  always_comb begin
    // Errors and writes return zero data; only clean reads pass SRAM data through.
    rdata = 32'h0;
    if (resp_q.owner != OWNER_NONE && !resp_q.err && !wr_q) begin
      rdata = mem_rdata_i;
    end
    instr_rvalid_o = (resp_q.owner == OWNER_INSTR);
    data_rvalid_o  = (resp_q.owner == OWNER_DATA);
    instr_rdata_o  = instr_rvalid_o ? rdata : 32'h0;
    data_rdata_o   = data_rvalid_o ? rdata : 32'h0;
    instr_err_o    = instr_rvalid_o & resp_q.err;
    data_err_o     = data_rvalid_o & resp_q.err;
  end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM between the Ibex fetch port and the LSU data port.
// Latency: grant combinational (zero cycles); response one cycle after grant.
// Backpressure: losing port sees gnt=0 and holds its request; out-of-range requests are granted with err.
// Ports: clk_sys/rst_sys_n; instr_* fetch request/response; data_* LSU request/response;
//        mem_* SRAM request, mem_rdata_i SRAM read data (valid one cycle after mem_req_o).
// Build option: define SRAM_ARB_STARVE_GUARD_EN to bound instruction starvation to StarveLimit data
//               grants; undefined gives fixed data-first priority.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [31:0] MemStart    = 32'h0000_0000,
  parameter int unsigned MemSize     = 65536,
  parameter int unsigned StarveLimit = 4
) (
  input  logic        clk_sys,
  input  logic        rst_sys_n,
  input  logic        instr_req_i,
  input  logic [31:0] instr_addr_i,
  output logic        instr_gnt_o,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        data_req_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  logic  instr_win, data_win;
  logic  instr_ok, data_ok;
  resp_t resp_nxt;
  logic  wr_nxt;

  assign instr_ok = in_range(instr_addr_i, MemStart, MemSize);
  assign data_ok  = in_range(data_addr_i, MemStart, MemSize);

`ifdef SRAM_ARB_STARVE_GUARD_EN
  localparam int unsigned      StarveW   = $clog2(StarveLimit + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(StarveLimit);

  logic [StarveW-1:0] starve_d, starve_q;

  always_comb begin
    // Data wins ties until it has taken StarveLimit grants over a waiting fetch.
    data_win  = data_req_i && !(instr_req_i && (starve_q == StarveMax));
    instr_win = instr_req_i && !data_win;
    starve_d  = starve_q;
    if (!instr_req_i || instr_win) begin
      starve_d = '0;
    end else if (data_win && (starve_q != StarveMax)) begin
      starve_d = starve_q + StarveW'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  // Fixed priority: the starvation limit has no effect in this build.
  logic unused_starve_limit;
  assign unused_starve_limit = ^StarveLimit;

  always_comb begin
    data_win  = data_req_i;
    instr_win = instr_req_i && !data_req_i;
  end
`endif

  assign instr_gnt_o = instr_win;
  assign data_gnt_o  = data_win;

  always_comb begin
    mem_req_o   = 1'b0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    resp_nxt    = '{owner: OWNER_NONE, err: 1'b0};
    wr_nxt      = 1'b0;
    // Out-of-range winners are still granted, but never reach the SRAM.
    if (data_win) begin
      resp_nxt = '{owner: OWNER_DATA, err: !data_ok};
      wr_nxt   = data_we_i;
      if (data_ok) begin
        mem_req_o   = 1'b1;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_addr_o  = data_addr_i;
        mem_wdata_o = data_wdata_i;
      end
    end else if (instr_win) begin
      resp_nxt = '{owner: OWNER_INSTR, err: !instr_ok};
      if (instr_ok) begin
        mem_req_o  = 1'b1;
        mem_be_o   = 4'hF;
        mem_addr_o = instr_addr_i;
      end
    end
  end

  sram_arb_resp u_resp (
    .clk_sys        (clk_sys),
    .rst_sys_n      (rst_sys_n),
    .resp_i         (resp_nxt),
    .wr_i           (wr_nxt),
    .mem_rdata_i    (mem_rdata_i),
    .instr_rvalid_o (instr_rvalid_o),
    .instr_rdata_o  (instr_rdata_o),
    .instr_err_o    (instr_err_o),
    .data_rvalid_o  (data_rvalid_o),
    .data_rdata_o   (data_rdata_o),
    .data_err_o     (data_err_o)
  );

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter: directed table, contention, reset and random traffic.
// Latency: checks grants in the request cycle and responses one cycle later.
// Backpressure: stimulus holds a request until the reference model says it was granted.
module tb_sram_port_arbiter;

  localparam logic [31:0] MEM_START    = 32'h0000_0000;
  localparam int unsigned MEM_SIZE     = 65536;
  localparam int          STARVE_LIMIT = 4;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        instr_req = 1'b0;
  logic [31:0] instr_addr = '0;
  logic        instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_rdata;
  logic        data_req = 1'b0, data_we = 1'b0;
  logic [3:0]  data_be = '0;
  logic [31:0] data_addr = '0, data_wdata = '0;
  logic        data_gnt, data_rvalid, data_err;
  logic [31:0] data_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;

  always #5 clk_sys = ~clk_sys;

  sram_port_arbiter #(.MemStart(MEM_START), .MemSize(MEM_SIZE), .StarveLimit(STARVE_LIMIT)) dut (
    .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
    .instr_req_i(instr_req), .instr_addr_i(instr_addr), .instr_gnt_o(instr_gnt),
    .instr_rvalid_o(instr_rvalid), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_rdata_o(data_rdata), .data_err_o(data_err),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_be_o(mem_be), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
  );

  // Behavioural single-port SRAM (the device under the arbiter).
  logic [31:0] sram [16384];
  always @(posedge clk_sys) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) sram[mem_addr[15:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
      mem_rdata <= sram[mem_addr[15:2]];
    end
  end

  // Reference model state.
  logic [31:0] ref_mem [16384];
  int          m_starve = 0;
  bit          exp_v = 0, exp_port = 0, exp_err = 0;
  logic [31:0] exp_rdata = '0;
  bit          m_ig = 0, m_dg = 0;
  int          n_checks = 0, n_errs = 0;

  function automatic bit in_rng(input logic [31:0] a);
    return (a & ~(MEM_SIZE - 1)) == MEM_START;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance the model.
  task automatic step();
    bit ig, dg, iok, dok;
    logic [69:0] exp_bus;
    logic [67:0] exp_rsp;
    @(negedge clk_sys);
    if (!rst_sys_n) begin
      exp_v = 0;
      m_starve = 0;
    end
    ig = 0; dg = 0;
    if (instr_req && data_req) begin
`ifdef SRAM_ARB_STARVE_GUARD_EN
      if (m_starve == STARVE_LIMIT) ig = 1; else dg = 1;
`else
      dg = 1;
`endif
    end else begin
      ig = instr_req;
      dg = data_req;
    end
    iok = in_rng(instr_addr);
    dok = in_rng(data_addr);
    exp_bus = '0;
    if (dg && dok) exp_bus = {1'b1, data_we, data_be, data_addr, data_wdata};
    else if (ig && iok) exp_bus = {1'b1, 1'b0, 4'hF, instr_addr, 32'h0};
    exp_rsp = '0;
    if (exp_v && !exp_port) exp_rsp = {1'b1, exp_rdata, exp_err, 1'b0, 32'h0, 1'b0};
    if (exp_v && exp_port)  exp_rsp = {1'b0, 32'h0, 1'b0, 1'b1, exp_rdata, exp_err};
    chk("grant", {126'h0, instr_gnt, data_gnt}, {126'h0, ig, dg});
    chk("mem_bus", {58'h0, mem_req, mem_we, mem_be, mem_addr, mem_wdata}, {58'h0, exp_bus});
    chk("response", {60'h0, instr_rvalid, instr_rdata, instr_err, data_rvalid, data_rdata, data_err},
        {60'h0, exp_rsp});
    exp_v = ig | dg;
    exp_port = dg;
    exp_err = dg ? !dok : !iok;
    exp_rdata = '0;
    if (dg && dok) begin
      if (data_we) begin
        for (int b = 0; b < 4; b++)
          if (data_be[b]) ref_mem[data_addr[15:2]][8*b +: 8] = data_wdata[8*b +: 8];
      end else exp_rdata = ref_mem[data_addr[15:2]];
    end else if (ig && iok) exp_rdata = ref_mem[instr_addr[15:2]];
    if (!instr_req || ig) m_starve = 0;
    else if (dg && m_starve < STARVE_LIMIT) m_starve++;
    m_ig = ig;
    m_dg = dg;
    @(posedge clk_sys);
    #1;
  endtask

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        dr, dwe;
    logic [3:0]  dbe;
    logic [31:0] da, dwd;
    logic        eig, edg, emreq;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0, 1, 2: return {18'h0, 12'($urandom_range(0, 2047)), 2'b00};
      3:       return MEM_START + MEM_SIZE - 4;
      4:       return MEM_START + MEM_SIZE;
      default: return 32'h8000_0000;
    endcase
  endfunction

  initial begin
    int first_ig, n_ig;
    for (int i = 0; i < 16384; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    sram[32'h80 >> 2] = 32'h0000_0013;
    ref_mem[32'h80 >> 2] = 32'h0000_0013;

    //            ir  ia            dr dwe be     da            dwd           ig dg mreq
    vecs.push_back('{1, 32'h80,       0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0});
    vecs.push_back('{0, 32'h0,        1, 1, 4'hF, 32'h1000,     32'hDEADBEEF, 0, 1, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'h1000,     32'h0,        0, 1, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'h0001_0000, 32'h0,       0, 1, 0});
    vecs.push_back('{1, 32'hFFFC,     0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{1, 32'h0001_0000, 0, 0, 4'h0, 32'h0,       32'h0,        1, 0, 0});
    vecs.push_back('{1, 32'h80,       1, 0, 4'hF, 32'h0002_0000, 32'h0,       0, 1, 0});
    vecs.push_back('{1, 32'h84,       0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{0, 32'h0,        1, 1, 4'h3, 32'h1000,     32'h12345678, 0, 1, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'h1000,     32'h0,        0, 1, 1});
    vecs.push_back('{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0});
    // Alternating instr/data grants: six back-to-back responses.
    vecs.push_back('{1, 32'h80,       0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'h1000,     32'h0,        0, 1, 1});
    vecs.push_back('{1, 32'h84,       0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'h1004,     32'h0,        0, 1, 1});
    vecs.push_back('{1, 32'h88,       0, 0, 4'h0, 32'h0,        32'h0,        1, 0, 1});
    vecs.push_back('{0, 32'h0,        1, 0, 4'hF, 32'hFFFC,     32'h0,        0, 1, 1});
    vecs.push_back('{0, 32'h0,        0, 0, 4'h0, 32'h0,        32'h0,        0, 0, 0});

    // Reset state with no requests.
    step();
    step();
    rst_sys_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      instr_req = vecs[i].ir;  instr_addr = vecs[i].ia;
      data_req = vecs[i].dr;   data_we = vecs[i].dwe;  data_be = vecs[i].dbe;
      data_addr = vecs[i].da;  data_wdata = vecs[i].dwd;
      #2;
      chk($sformatf("vec%0d_gnt_memreq", i), {125'h0, instr_gnt, data_gnt, mem_req},
          {125'h0, vecs[i].eig, vecs[i].edg, vecs[i].emreq});
      step();
    end

    // Contention: both ports request continuously for ten cycles.
    instr_req = 1; instr_addr = 32'h80;
    data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h1000;
    first_ig = -1;
    n_ig = 0;
    for (int c = 0; c < 10; c++) begin
      if (instr_gnt) begin
        n_ig++;
        if (first_ig < 0) first_ig = c;
      end
      step();
    end
`ifdef SRAM_ARB_STARVE_GUARD_EN
    chk("contention_first_instr", 128'(first_ig), 128'(STARVE_LIMIT));
    chk("contention_instr_count", 128'(n_ig), 128'(10 / (STARVE_LIMIT + 1)));
`else
    chk("contention_first_instr", 128'(first_ig), 128'(-1));
    chk("contention_instr_count", 128'(n_ig), 128'(0));
`endif
    instr_req = 0; data_req = 0;
    step();

    // Reset in the cycle after a grant drops the pending response.
    data_req = 1; data_we = 0; data_be = 4'hF; data_addr = 32'h1000;
    step();
    data_req = 0;
    rst_sys_n = 1'b0;
    #1;
    chk("reset_kills_rvalid", {126'h0, instr_rvalid, data_rvalid}, 128'h0);
    step();
    step();
    rst_sys_n = 1'b1;
    step();
    instr_req = 1; instr_addr = 32'h80;
    step();
    instr_req = 0;
    step();

    // Random traffic; a losing request is held stable until granted.
    for (int c = 0; c < 400; c++) begin
      if (!(instr_req && !m_ig)) begin
        instr_req = 1'($urandom_range(0, 1));
        instr_addr = rand_addr();
      end
      if (!(data_req && !m_dg)) begin
        data_req = 1'($urandom_range(0, 1));
        data_we = 1'($urandom_range(0, 1));
        data_be = 4'($urandom_range(0, 15));
        data_addr = rand_addr();
        data_wdata = $urandom;
      end
      step();
    end
    instr_req = 0; data_req = 0;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
